// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO word offsets, address
// regions and the byte-lane merge used by both RAM and MMIO registers.
package dmem_pkg;

    localparam logic [1:0] OFF_MTIME_LO = 2'd0;
    localparam logic [1:0] OFF_MTIME_HI = 2'd1;
    localparam logic [1:0] OFF_TOHOST   = 2'd2;
    localparam logic [1:0] OFF_SCRATCH  = 2'd3;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-writable word RAM: combinational read, synchronous lane-masked write.
// Contents are deliberately not reset so they survive a mid-run reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    byte_en,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    assign rdata = mem_r[addr];

    // Lane-masked write; an all-zero mask leaves the word untouched.
    always_ff @(posedge clk) begin
        if (byte_en != 4'h0) begin
            mem_r[addr] <= byte_merge(mem_r[addr], wdata, byte_en);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the rv32i data port: RAM plus a 16-byte MMIO window
// holding a free-running 64-bit MTIME, a scratch word and the tohost halt register.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_mem_addr,
    input  logic [3:0]  data_mem_wmask,
    input  logic [31:0] data_mem_write,
    input  logic        data_mem_w_en,
    output logic [31:0] data_mem_read,
    output logic        halt,
    output logic [31:0] tohost_value,
    output logic        access_fault
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    region_e     region_s;
    logic [1:0]  off_s;
    logic        wr_act_s;
    logic [3:0]  ram_be_s;
    logic [31:0] ram_rdata_s;
    logic [31:0] rdata_s;
    logic [31:0] tohost_merged_s;

    logic [63:0] mtime_r;
    logic [31:0] scratch_r;
    logic [31:0] tohost_r;
    logic        halt_r;
    logic        fault_r;

    assign off_s           = data_mem_addr[3:2];
    assign wr_act_s        = data_mem_w_en && !halt_r && (data_mem_wmask != 4'h0);
    assign tohost_merged_s = byte_merge(tohost_r, data_mem_write, data_mem_wmask);

    // Address decode into RAM, MMIO window or unmapped space.
    always_comb begin
        region_s = REG_NONE;
        if ({1'b0, data_mem_addr} < RAM_BYTES) begin
            region_s = REG_RAM;
        end else if (data_mem_addr[31:4] == MMIO_BASE[31:4]) begin
            region_s = REG_MMIO;
        end else begin
            region_s = REG_NONE;
        end
    end

    // RAM lane enables only for accepted writes that land in RAM.
    always_comb begin
        ram_be_s = 4'h0;
        if (wr_act_s && (region_s == REG_RAM)) begin
            ram_be_s = data_mem_wmask;
        end else begin
            ram_be_s = 4'h0;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk    (clk),
        .addr   (data_mem_addr[AW+1:2]),
        .byte_en(ram_be_s),
        .wdata  (data_mem_write),
        .rdata  (ram_rdata_s)
    );

    // Combinational read mux; same-cycle writes are not forwarded.
    always_comb begin
        rdata_s = 32'h0;
        case (region_s)
            REG_RAM: rdata_s = ram_rdata_s;
            REG_MMIO: begin
                case (off_s)
                    OFF_MTIME_LO: rdata_s = mtime_r[31:0];
                    OFF_MTIME_HI: rdata_s = mtime_r[63:32];
                    OFF_TOHOST:   rdata_s = tohost_r;
                    OFF_SCRATCH:  rdata_s = scratch_r;
                    default:      rdata_s = 32'h0;
                endcase
            end
            default: rdata_s = 32'h0;
        endcase
    end

    // MMIO registers and sticky flags; everything freezes once halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_r   <= 64'h0;
            scratch_r <= 32'h0;
            tohost_r  <= 32'h0;
            halt_r    <= 1'b0;
            fault_r   <= 1'b0;
        end else if (!halt_r) begin
            mtime_r <= mtime_r + 64'd1;
            if (wr_act_s) begin
                case (region_s)
                    REG_MMIO: begin
                        case (off_s)
                            OFF_TOHOST: begin
                                tohost_r <= tohost_merged_s;
                                if (tohost_merged_s != 32'h0) begin
                                    halt_r <= 1'b1;
                                end
                            end
                            OFF_SCRATCH: scratch_r <= byte_merge(scratch_r, data_mem_write, data_mem_wmask);
                            default: ;
                        endcase
                    end
                    REG_NONE: fault_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign data_mem_read = rdata_s;
    assign halt          = halt_r;
    assign tohost_value  = tohost_r;
    assign access_fault  = fault_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model,
// plus directed cases for lane merge, MTIME, halt, fault and async reset.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_mem_addr;
    logic [3:0]  data_mem_wmask;
    logic [31:0] data_mem_write;
    logic        data_mem_w_en;
    logic [31:0] data_mem_read;
    logic        halt;
    logic [31:0] tohost_value;
    logic        access_fault;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  ref_ram [DEPTH*4];
    logic [63:0] ref_mtime;
    logic [31:0] ref_tohost;
    logic [31:0] ref_scratch;
    logic        ref_halt;
    logic        ref_fault;
    int          init_words[$];
    logic [63:0] frozen_mtime;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_mem_addr (data_mem_addr),
        .data_mem_wmask(data_mem_wmask),
        .data_mem_write(data_mem_write),
        .data_mem_w_en (data_mem_w_en),
        .data_mem_read (data_mem_read),
        .halt          (halt),
        .tohost_value  (tohost_value),
        .access_fault  (access_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int base;
        if (a < 32'(DEPTH*4)) begin
            base = int'(a) & ~3;
            return {ref_ram[base+3], ref_ram[base+2], ref_ram[base+1], ref_ram[base]};
        end else if (a[31:4] == MB[31:4]) begin
            case (a[3:2])
                2'd0:    return ref_mtime[31:0];
                2'd1:    return ref_mtime[63:32];
                2'd2:    return ref_tohost;
                default: return ref_scratch;
            endcase
        end
        return 32'h0;
    endfunction

    // Model of one rising edge, using the halt state from before the edge.
    task automatic ref_step(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input logic we);
        logic was_halted;
        int   base;
        was_halted = ref_halt;
        if (we && !ref_halt && m != 4'h0) begin
            if (a < 32'(DEPTH*4)) begin
                base = int'(a) & ~3;
                for (int i = 0; i < 4; i++)
                    if (m[i]) ref_ram[base+i] = d[8*i +: 8];
            end else if (a[31:4] == MB[31:4]) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i] && a[3:2] == 2'd2) ref_tohost[8*i +: 8] = d[8*i +: 8];
                    if (m[i] && a[3:2] == 2'd3) ref_scratch[8*i +: 8] = d[8*i +: 8];
                end
                if (a[3:2] == 2'd2 && ref_tohost != 32'h0) ref_halt = 1'b1;
            end else begin
                ref_fault = 1'b1;
            end
        end
        if (!was_halted) ref_mtime = ref_mtime + 64'd1;
    endtask

    task automatic cycle(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input logic we);
        data_mem_addr  = a;
        data_mem_wmask = m;
        data_mem_write = d;
        data_mem_w_en  = we;
        @(negedge clk);
        #1;
        check_eq("rdata", data_mem_read, ref_read(a));
        check_eq("halt", halt, ref_halt);
        check_eq("access_fault", access_fault, ref_fault);
        check_eq("tohost_value", tohost_value, ref_tohost);
        @(posedge clk);
        #1;
        ref_step(a, m, d, we);
    endtask

    // Drops reset mid-cycle, checks the asynchronous clear, releases after an edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        data_mem_w_en = 1'b0;
        reset         = 1'b0;
        ref_mtime = 64'h0; ref_tohost = 32'h0; ref_scratch = 32'h0;
        ref_halt  = 1'b0;  ref_fault  = 1'b0;
        data_mem_addr = MB;
        #1;
        check_eq("rst_halt", halt, 1'b0);
        check_eq("rst_fault", access_fault, 1'b0);
        check_eq("rst_tohost", tohost_value, 32'h0);
        check_eq("rst_mtime", data_mem_read, 32'h0);
        data_mem_addr = MB + 32'd12;
        #1;
        check_eq("rst_scratch", data_mem_read, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  off;
        int          sel;
        reset = 1'b0; data_mem_addr = 32'h0; data_mem_wmask = 4'h0;
        data_mem_write = 32'h0; data_mem_w_en = 1'b0;
        do_reset();

        for (int w = 0; w < 64; w++) init_words.push_back(w);
        for (int w = DEPTH - 4; w < DEPTH; w++) init_words.push_back(w);
        foreach (init_words[i]) cycle(32'(init_words[i] * 4), 4'hF, $urandom, 1'b1);

        cycle(32'h10, 4'hF, 32'h1122_3344, 1'b1);
        cycle(32'h10, 4'b0101, 32'hAABB_CCDD, 1'b1);
        check_eq("lane_merge", data_mem_read, 32'h11BB_33DD);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            d   = $urandom;
            if (sel <= 4) begin
                a = 32'(init_words[$urandom_range(0, init_words.size() - 1)] * 4) | 32'($urandom_range(0, 3));
            end else if (sel <= 6) begin
                off = 2'($urandom_range(0, 3));
                a   = MB | {28'h0, off, 2'($urandom_range(0, 3))};
                if (off == 2'd2) d = 32'h0;
            end else if (sel == 7) begin
                a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
            end else if (sel == 8) begin
                a = 32'(DEPTH*4) + 32'($urandom_range(0, 255) * 4);
            end else begin
                a = MB + 32'd16 + 32'($urandom_range(0, 15));
            end
            cycle(a, 4'($urandom_range(0, 15)), d, 1'($urandom_range(0, 1)));
        end

        do_reset();
        repeat (100) cycle(MB, 4'h0, 32'h0, 1'b0);
        check_eq("mtime_100", data_mem_read, 32'd100);
        data_mem_addr = MB + 32'd4;
        #1;
        check_eq("mtime_hi", data_mem_read, 32'h0);
        cycle(MB, 4'hF, 32'hFFFF_FFFF, 1'b1);
        cycle(MB, 4'h0, 32'h0, 1'b0);
        check_eq("mtime_ro", data_mem_read, 32'd102);

        do_reset();
        cycle(32'h4000_0000, 4'h0, 32'h1234_5678, 1'b1);
        check_eq("fault_mask0", access_fault, 1'b0);
        cycle(32'h4000_0000, 4'hF, 32'h1234_5678, 1'b1);
        check_eq("fault_set", access_fault, 1'b1);
        check_eq("unmapped_rd", data_mem_read, 32'h0);

        cycle(MB + 32'd8, 4'hF, 32'h0, 1'b1);
        check_eq("tohost0_halt", halt, 1'b0);
        check_eq("tohost0_val", tohost_value, 32'h0);
        cycle(MB + 32'd8, 4'hF, 32'h1, 1'b1);
        check_eq("halt_set", halt, 1'b1);
        check_eq("halt_tohost", tohost_value, 32'h1);
        frozen_mtime = ref_mtime;
        cycle(32'h20, 4'hF, ~ref_read(32'h20), 1'b1);
        cycle(32'h20, 4'h0, 32'h0, 1'b0);
        cycle(MB, 4'h0, 32'h0, 1'b0);
        repeat (10) cycle(MB, 4'h0, 32'h0, 1'b0);
        check_eq("mtime_frozen", data_mem_read, frozen_mtime[31:0]);

        do_reset();
        cycle(MB + 32'd12, 4'hF, 32'hDEAD_BEEF, 1'b1);
        cycle(32'h8, 4'hF, 32'hCAFE_F00D, 1'b1);
        cycle(32'h4000_0000, 4'hF, 32'h0, 1'b1);
        cycle(MB + 32'd8, 4'hF, 32'h5, 1'b1);
        cycle(MB + 32'd12, 4'h0, 32'h0, 1'b0);
        do_reset();
        cycle(32'h8, 4'h0, 32'h0, 1'b0);
        check_eq("ram_retained", data_mem_read, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory slave for the rv32i_cpu data port. It answers the CPU's address, byte-mask, write-data and write-enable outputs with read data. It contains a byte-writable RAM and a small MMIO window: a free-running cycle counter, a scratch register, and a tohost halt register. It is instantiated beside the CPU in simulation and FPGA tops, where it replaces the free random read data.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two; RAM spans 0x0000_0000 to DEPTH_WORDS*4-1.
MMIO_BASE, 32'h8000_0000, base of the 16-byte MMIO window.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
data_mem_addr  in  32  byte address from CPU; bits [1:0] ignored (lanes already aligned by CPU).
data_mem_wmask  in  4  byte-lane write mask; bit i selects bits [8i+7:8i].
data_mem_write  in  32  write data, lane-aligned.
data_mem_w_en  in  1  write request for this cycle.
data_mem_read  out  32  read data for data_mem_addr, same cycle.
halt  out  1  sticky; set after a nonzero tohost write.
tohost_value  out  32  current TOHOST register.
access_fault  out  1  sticky; set after a write to an unmapped address.

Behaviour:
- Reset (reset=0, async):
  - halt=0, access_fault=0, tohost_value=0.
  - MTIME=0, SCRATCH=0.
  - RAM contents are not reset and are retained across a mid-run reset.
- Read path is combinational, with no read enable. data_mem_read is valid in the same cycle for any address.
  - RAM hit (addr < DEPTH_WORDS*4): word addr[log2(DEPTH_WORDS)+1:2].
  - MMIO hit (addr[31:4]==MMIO_BASE[31:4]), by offset addr[3:2]:
    - 0: MTIME[31:0]
    - 1: MTIME[63:32]
    - 2: TOHOST
    - 3: SCRATCH
  - Unmapped: 32'h0.
- Write path, at the rising edge when data_mem_w_en=1 and halt=0:
  - Each lane with wmask[i]=1 takes data_mem_write lane i; other lanes are unchanged.
  - w_en=1 with wmask=0: no change, no fault.
  - MTIME offsets are read-only; writes to them are silently ignored.
  - TOHOST: merged value stored. If the merged value is nonzero, halt=1 from the next cycle. A merged value of 0 stores 0 and does not halt.
  - Write to an unmapped address: access_fault=1 from the next cycle. Nothing is stored.
- Same-cycle read and write to one address: data_mem_read shows the old value; the new value is visible the next cycle.
- MTIME: 64-bit counter, +1 every cycle while halt=0.
  - Wraps 2^64-1 to 0.
  - Frozen while halt=1.
- Once halt=1, all writes are ignored (RAM, SCRATCH and TOHOST all frozen). Reads still work. Only reset clears halt.
- access_fault does not block further accesses.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants (OFF_MTIME_LO=0, OFF_MTIME_HI=1, OFF_TOHOST=2, OFF_SCRATCH=3).
  - An address-region enum {REG_RAM, REG_MMIO, REG_NONE}.
  - Function byte_merge(old, new, mask) returning the lane-merged word, shared by RAM and MMIO.
- Sub-module dmem_ram: DEPTH_WORDS x 32 array with per-byte write enables, combinational read and synchronous write, no reset. All decode, the MMIO registers and the sticky flags stay in dmem_responder.

Test Plan:
- Byte-lane merge: write 0x11223344 with mask 4'hF to addr 0x10, then 0xAABBCCDD with mask 4'b0101 to 0x10 -> read at 0x10 = 0x11BB33DD. Read in the write cycle returns the prior value.
- MTIME: release reset, idle 100 cycles -> read MMIO_BASE+0 = 100 ±1 per the defined sample edge, +4 reads 0. A write of 0xFFFFFFFF to MMIO_BASE+0 has no effect.
- Halt:
  - Write 0 to MMIO_BASE+8 -> halt stays 0, tohost_value=0.
  - Write 0x00000001 -> halt=1 the next cycle, tohost_value=1.
  - A subsequent RAM write to 0x20 does not change its contents.
  - MTIME is constant on two reads 10 cycles apart.
- Fault: write to 0x4000_0000 with mask 4'hF -> access_fault=1 the next cycle and a read there returns 0. w_en=1 with mask 0 to 0x4000_0000 on a fresh run -> access_fault stays 0.
- Async reset mid-run: write SCRATCH=0xDEADBEEF and RAM[0x8]=0xCAFEF00D, then drop reset mid-cycle -> halt, access_fault, tohost_value, MTIME and SCRATCH are 0 immediately, and RAM[0x8] still reads 0xCAFEF00D after reset release.
